// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: FSM state encoding,
// Booth recoding values and the default operand width used by the datapath.
package booth_pkg;

  localparam int DEF_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXAM  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_t;

  // Radix-2 recoding of the pair {Q0, Q(-1)}: 01 adds M, 10 subtracts M.
  function automatic booth_t booth_decode(input logic q0, input logic qm1);
    booth_t code;
    case ({q0, qm1})
      2'b01:   code = BOOTH_ADD;
      2'b10:   code = BOOTH_SUB;
      default: code = BOOTH_NOP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Booth iteration counter: cleared at operand load, advanced once per shift,
// holds at WIDTH-1 so it never wraps.
module booth_iter_cnt
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/booth_ctrl.sv
// Sequencing controller for the radix-2 Booth multiplier: load, then WIDTH
// rounds of examine/shift, then a one-cycle done pulse back to IDLE.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  output logic ready,
  output logic init,
  output logic ld_m,
  output logic ld_q,
  output logic ld_acc,
  output logic addsub,
  output logic sh,
  output logic done
);

  state_t state;
  booth_t code;
  logic   last;

  booth_iter_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == ST_LOAD),
    .inc  (state == ST_SHIFT),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state <= ST_LOAD;
        ST_LOAD:  state <= ST_EXAM;
        ST_EXAM:  state <= ST_SHIFT;
        ST_SHIFT: state <= last ? ST_DONE : ST_EXAM;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign code = booth_decode(q0, qm1);

  // Moore decode: only EXAM looks at the datapath bits, which are stable there.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned and infers a latch.
    ready  = 1'b0;
    init   = 1'b0;
    ld_m   = 1'b0;
    ld_q   = 1'b0;
    ld_acc = 1'b0;
    addsub = 1'b0;
    sh     = 1'b0;
    done   = 1'b0;
    case (state)
      ST_IDLE: ready = 1'b1;
      ST_LOAD: begin
        init = 1'b1;
        ld_m = 1'b1;
        ld_q = 1'b1;
      end
      ST_EXAM: begin
        ld_acc = (code != BOOTH_NOP);
        addsub = (code == BOOTH_SUB);
      end
      ST_SHIFT: sh   = 1'b1;
      ST_DONE:  done = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: a guarded-accumulator datapath model closes the loop,
// and a scoreboard checks every cycle of each operation against a timeline.
module tb_booth_ctrl;
  import booth_pkg::*;

  localparam int W   = DEF_WIDTH;
  localparam int LAT = 2 * W + 1;

  logic clk = 1'b0;
  logic rst, start, q0, qm1;
  logic ready, init, ld_m, ld_q, ld_acc, addsub, sh, done;

  always #5 clk = ~clk;

  booth_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .q0     (q0),
    .qm1    (qm1),
    .ready  (ready),
    .init   (init),
    .ld_m   (ld_m),
    .ld_q   (ld_q),
    .ld_acc (ld_acc),
    .addsub (addsub),
    .sh     (sh),
    .done   (done)
  );

  // Datapath: acc carries one guard bit so subtracting M = -2^(W-1) cannot overflow.
  logic [W:0]   acc   = '0;
  logic [W-1:0] qreg  = '0;
  logic [W-1:0] mreg  = '0;
  logic         qm1_r = 1'b0;
  logic [W-1:0] m_bus = '0;
  logic [W-1:0] q_bus = '0;

  assign q0  = qreg[0];
  assign qm1 = qm1_r;

  always @(posedge clk) begin
    if (init) begin
      acc   <= '0;
      qm1_r <= 1'b0;
    end
    if (ld_m) mreg <= m_bus;
    if (ld_q) qreg <= q_bus;
    if (ld_acc) acc <= addsub ? acc - {mreg[W-1], mreg} : acc + {mreg[W-1], mreg};
    if (sh) {acc, qreg, qm1_r} <= {acc[W], acc, qreg};
  end

  typedef struct {
    logic [2*W-1:0] prod;
    int             nadd;
    int             e;
  } item_t;

  item_t sbq[$];
  int    acc_es[$];
  int    done_cycs[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: signed product and number of 01/10 pairs scanning the multiplier.
  function automatic item_t make_item(input logic [W-1:0] a, input logic [W-1:0] b, input int e);
    item_t it;
    int    sa, sb, p;
    logic  prev;
    sa = {{(32-W){a[W-1]}}, a};
    sb = {{(32-W){b[W-1]}}, b};
    p  = sa * sb;
    it.prod = p[2*W-1:0];
    it.nadd = 0;
    prev = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (b[i] != prev) it.nadd++;
      prev = b[i];
    end
    it.e = e;
    return it;
  endfunction

  // Issue side: a start seen while the bench believes the controller is idle.
  always @(posedge clk) begin
    if (!rst && start && sbq.size() == 0) begin
      sbq.push_back(make_item(m_bus, q_bus, cyc + 1));
      acc_es.push_back(cyc + 1);
    end
  end

  int sh_seen  = 0;
  int add_seen = 0;

  // Monitor: j counts cycles since the accepting edge.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      sh_seen  = 0;
      add_seen = 0;
    end else if (sbq.size() == 0) begin
      check("idle_outputs", {ready, init, ld_m, ld_q, ld_acc, sh, done}, 32'b1000000);
    end else begin
      int j;
      j = cyc - sbq[0].e;
      if (j < LAT) begin
        sh_seen  += int'(sh);
        add_seen += int'(ld_acc);
      end
      if (j == 0) begin
        check("load", {ready, init, ld_m, ld_q, ld_acc, sh, done}, 32'b0111000);
      end else if (j < LAT && j[0]) begin
        check("exam_other", {ready, init, ld_m, ld_q, sh, done}, 32'b0);
        check("exam_ld_acc", ld_acc, q0 ^ qm1);
        if (q0 ^ qm1) check("exam_addsub", addsub, q0);
      end else if (j < LAT) begin
        check("shift", {ready, init, ld_m, ld_q, ld_acc, sh, done}, 32'b0000010);
      end else if (j == LAT) begin
        check("done_frame", {ready, init, ld_m, ld_q, ld_acc, sh, done}, 32'b0000001);
        check("product", {acc[W-1:0], qreg}, sbq[0].prod);
        check("sh_pulses", sh_seen, W);
        check("ld_acc_pulses", add_seen, sbq[0].nadd);
        done_cycs.push_back(cyc);
      end else begin
        check("ready_return", {ready, done}, 32'b10);
        void'(sbq.pop_front());
        sh_seen  = 0;
        add_seen = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (sbq.size() == 0) return;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_err++;
    $display("FAIL idle_timeout: operation still pending after 100 cycles (cycle %0d)", cyc);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    m_bus = a;
    q_bus = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, a0, e;
    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    do_op(6'd7, 6'd3);
    do_op(6'b111011, 6'd6);
    do_op(6'b100000, 6'b100000);

    for (int i = 0; i < 16; i++) begin
      wait_idle();
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      do_op(W'($urandom), W'($urandom));
    end

    // start held high across two operations
    wait_idle();
    n0 = done_cycs.size();
    a0 = acc_es.size();
    m_bus = 6'b101101;
    q_bus = 6'b010011;
    start = 1'b1;
    for (int k = 0; k < 60 && acc_es.size() < a0 + 2; k++) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();
    if (acc_es.size() >= a0 + 2 && done_cycs.size() >= n0 + 1)
      check("relaunch_gap", acc_es[a0+1] - done_cycs[n0], 2);
    else
      check("relaunch_count", acc_es.size() - a0, 2);

    // reset during the third shift aborts the operation
    do_op(6'd7, 6'd3);
    e = acc_es[acc_es.size()-1];
    for (int k = 0; k < 20 && cyc < e + 6; k++) begin
      @(posedge clk);
      #1;
    end
    check("abort_in_shift", sh, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_no_done", done, 1'b0);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    do_op(6'd7, 6'd3);
    wait_idle();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
